// File: rtl/cosine_feeder_if.sv
// Handshake and engine-side bus between cosine_feeder and its environment.
// master: the feeder; slave: the byte source, result consumer and cosine engine.
interface cosine_feeder_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [31:0] A_vec;
    logic [31:0] B_vec;
    logic        core_rst_n;
    logic        start;
    logic        done;
    logic [15:0] cosine_similarity;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_timeout;

    modport master (
        input  in_valid, in_data, done, cosine_similarity, res_ready,
        output in_ready, A_vec, B_vec, core_rst_n, start, res_valid, res_data, res_timeout
    );

    modport slave (
        output in_valid, in_data, done, cosine_similarity, res_ready,
        input  in_ready, A_vec, B_vec, core_rst_n, start, res_valid, res_data, res_timeout
    );
endinterface

// File: rtl/cosine_feeder.sv
// Packs two 4-byte vectors from a byte stream, re-arms and starts the cosine engine, then returns its result.
// Optional WAIT timeout is enabled by defining COSINE_FEEDER_TIMEOUT_EN.
module cosine_feeder #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic            clk,
    input  logic            reset,
    cosine_feeder_if.master bus
);
    localparam int unsigned VEC_W = 32;
    localparam int unsigned RES_W = 16;

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        ARM,
        START,
        WAIT,
        RESULT
    } state_t;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [VEC_W-1:0]   a_q, a_d;
    logic [VEC_W-1:0]   b_q, b_d;
    logic [RES_W-1:0]   res_data_q, res_data_d;
    logic               in_ready_q, in_ready_d;
    logic               core_rst_n_q, core_rst_n_d;
    logic               start_q, start_d;
    logic               res_valid_q, res_valid_d;
    logic               accept;
`ifdef COSINE_FEEDER_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               res_timeout_q, res_timeout_d;
`endif

    assign accept = bus.in_valid && in_ready_q;

    // Next state and datapath; control outputs are decoded from the next state so they are registered.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        res_data_d = res_data_q;
`ifdef COSINE_FEEDER_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
        res_timeout_d = res_timeout_q;
`endif
        unique case (state_q)
            LOAD_A: begin
                if (accept) begin
                    a_d[{cnt_q, 3'b000} +: 8] = bus.in_data;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (accept) begin
                    b_d[{cnt_q, 3'b000} +: 8] = bus.in_data;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = ARM;
                end
            end
            // done may still be stale from the previous operation here, so it is not looked at
            ARM: state_d = START;
            START: begin
                state_d = WAIT;
`ifdef COSINE_FEEDER_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            WAIT: begin
                if (bus.done) begin
                    res_data_d = bus.cosine_similarity;
                    state_d    = RESULT;
`ifdef COSINE_FEEDER_TIMEOUT_EN
                    res_timeout_d = 1'b0;
                end else if (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                    res_data_d    = '0;
                    res_timeout_d = 1'b1;
                    state_d       = RESULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
`endif
                end
            end
            RESULT: begin
                if (res_valid_q && bus.res_ready) begin
                    state_d = LOAD_A;
                    cnt_d   = 2'd0;
                end
            end
            default: state_d = LOAD_A;
        endcase

        in_ready_d   = (state_d == LOAD_A) || (state_d == LOAD_B);
        core_rst_n_d = (state_d != ARM);
        start_d      = (state_d == START);
        res_valid_d  = (state_d == RESULT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= LOAD_A;
            cnt_q        <= 2'd0;
            a_q          <= '0;
            b_q          <= '0;
            res_data_q   <= '0;
            in_ready_q   <= 1'b1;
            core_rst_n_q <= 1'b0;
            start_q      <= 1'b0;
            res_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_data_q   <= res_data_d;
            in_ready_q   <= in_ready_d;
            core_rst_n_q <= core_rst_n_d;
            start_q      <= start_d;
            res_valid_q  <= res_valid_d;
        end
    end

`ifdef COSINE_FEEDER_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q    <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    assign bus.res_timeout = res_timeout_q;
`else
    assign bus.res_timeout = 1'b0;
`endif

    assign bus.in_ready   = in_ready_q;
    assign bus.A_vec      = a_q;
    assign bus.B_vec      = b_q;
    assign bus.core_rst_n = core_rst_n_q;
    assign bus.start      = start_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_data_q;
endmodule

// File: tb/tb_cosine_feeder.sv
// Scoreboard bench for cosine_feeder with a behavioural cosine engine (sticky done, programmable latency).
module tb_cosine_feeder;
    localparam int unsigned TO = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cosine_feeder_if bus ();
    cosine_feeder #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cnt = 0;

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [16:0] qr[$];

    // Engine model: done is sticky; cleared by core_rst_n (unless stale_mode) and by start.
    logic        busy;
    int          eng_cnt;
    int          eng_lat = 0;
    logic [15:0] eng_val = 16'h0;
    bit          eng_never = 1'b0;
    bit          stale_mode = 1'b0;

    always @(posedge clk) begin
        if (!bus.core_rst_n && !stale_mode) begin
            bus.done <= 1'b0;
            busy     <= 1'b0;
        end else if (bus.start) begin
            bus.done <= 1'b0;
            busy     <= !eng_never;
            eng_cnt  <= eng_lat;
        end else if (busy) begin
            if (eng_cnt == 0) begin
                bus.done              <= 1'b1;
                bus.cosine_similarity <= eng_val;
                busy                  <= 1'b0;
            end else begin
                eng_cnt <= eng_cnt - 1;
            end
        end
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) acc_cnt = acc_cnt + 1;
    end

    task automatic send_byte(input logic [7:0] d, input bit gap);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL send_byte: byte %h never accepted", d);
        end
        if (gap) begin
            bus.in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_vecs(input logic [31:0] a, input logic [31:0] b, input logic [15:0] r,
                             input int lat, input bit gap, input bit hold, input bit exp_to);
        logic [31:0] v;
        int sh;
        eng_val = r;
        eng_lat = lat;
        qa.push_back(a);
        qb.push_back(b);
        qr.push_back(exp_to ? 17'h10000 : {1'b0, r});
        for (int k = 0; k < 8; k++) begin
            v  = (k < 4) ? a : b;
            sh = 8 * (k % 4);
            send_byte(v[sh +: 8], gap && (k != 7));
        end
        if (hold) bus.in_data = 8'hEE;
        else bus.in_valid = 1'b0;
    endtask

    task automatic collect(input int hold, input int exp_rel);
        logic [31:0] ea, eb;
        logic [16:0] er;
        int scyc;
        bit got;
        if (qa.size() == 0) begin
            checks++; failures++;
            $display("FAIL scoreboard: no expected entry");
            return;
        end
        ea = qa.pop_front();
        eb = qb.pop_front();
        er = qr.pop_front();
        @(negedge clk);
        checks++;
        if (bus.core_rst_n !== 1'b0 || bus.start !== 1'b0) begin
            failures++;
            $display("FAIL arm_cycle: core_rst_n=%b start=%b, required 0 0", bus.core_rst_n, bus.start);
        end
        checks++;
        if (bus.A_vec !== ea) begin
            failures++; $display("FAIL a_vec: got %h required %h", bus.A_vec, ea);
        end
        checks++;
        if (bus.B_vec !== eb) begin
            failures++; $display("FAIL b_vec: got %h required %h", bus.B_vec, eb);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++; $display("FAIL ready_in_arm: got %b required 0", bus.in_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.core_rst_n !== 1'b1 || bus.start !== 1'b1) begin
            failures++;
            $display("FAIL start_cycle: core_rst_n=%b start=%b, required 1 1", bus.core_rst_n, bus.start);
        end
        scyc = cyc;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.start !== 1'b0 || bus.core_rst_n !== 1'b1) begin
            failures++;
            $display("FAIL start_single: core_rst_n=%b start=%b, required 1 0", bus.core_rst_n, bus.start);
        end
        got = 1'b0;
        for (int t = 0; t < 2000 && !got; t++) begin
            if (bus.res_valid === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL res_valid_wait: res_valid never rose");
            return;
        end
        checks++;
        if (cyc - scyc !== exp_rel) begin
            failures++; $display("FAIL result_latency: got %0d required %0d", cyc - scyc, exp_rel);
        end
        checks++;
        if ({bus.res_timeout, bus.res_data} !== er) begin
            failures++;
            $display("FAIL result: got to=%b data=%h required to=%b data=%h",
                     bus.res_timeout, bus.res_data, er[16], er[15:0]);
        end
        checks++;
        if (bus.A_vec !== ea || bus.B_vec !== eb) begin
            failures++; $display("FAIL vec_hold: got %h/%h required %h/%h", bus.A_vec, bus.B_vec, ea, eb);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checks++;
            if (bus.res_valid !== 1'b1 || {bus.res_timeout, bus.res_data} !== er || bus.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL backpressure_hold: valid=%b data=%h ready=%b required 1 %h 0",
                         bus.res_valid, bus.res_data, bus.in_ready, er[15:0]);
            end
        end
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        checks++;
        if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL release: res_valid=%b in_ready=%b required 0 1", bus.res_valid, bus.in_ready);
        end
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (bus.A_vec !== 32'h0 || bus.B_vec !== 32'h0 || bus.res_data !== 16'h0 ||
            bus.res_valid !== 1'b0 || bus.res_timeout !== 1'b0 || bus.start !== 1'b0 ||
            bus.core_rst_n !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s: A=%h B=%h res=%h v=%b to=%b st=%b crn=%b rdy=%b required zeros, crn=0 rdy=1",
                     tag, bus.A_vec, bus.B_vec, bus.res_data, bus.res_valid, bus.res_timeout,
                     bus.start, bus.core_rst_n, bus.in_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset_state");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.core_rst_n !== 1'b1) begin
            failures++; $display("FAIL reset_release: core_rst_n=%b required 1", bus.core_rst_n);
        end
    endtask

    task automatic test_gapless();
        send_vecs(32'h04030201, 32'h08070605, 16'h1234, 3, 1'b0, 1'b0, 1'b0);
        collect(0, 6);
    endtask

    task automatic test_backpressure();
        send_vecs(32'hDEADBEEF, 32'h00FF7F80, 16'h0055, 2, 1'b0, 1'b0, 1'b0);
        collect(5, 5);
    endtask

    task automatic test_toggle_valid();
        int acc0;
        acc0 = acc_cnt;
        send_vecs(32'hA5A55A5A, 32'h13579BDF, 16'hBEEF, 0, 1'b1, 1'b1, 1'b0);
        collect(0, 3);
        checks++;
        if (acc_cnt - acc0 !== 8) begin
            failures++; $display("FAIL accept_count: got %0d required 8", acc_cnt - acc0);
        end
    endtask

    task automatic test_done_at_limit();
        send_vecs(32'hCAFEF00D, 32'h01234567, 16'h7777, int'(TO) - 2, 1'b0, 1'b0, 1'b0);
        collect(0, int'(TO) + 1);
    endtask

`ifdef COSINE_FEEDER_TIMEOUT_EN
    task automatic test_timeout();
        eng_never = 1'b1;
        send_vecs(32'h89ABCDEF, 32'hFEDCBA98, 16'h4321, 0, 1'b0, 1'b0, 1'b1);
        collect(2, int'(TO) + 1);
        eng_never = 1'b0;
    endtask
`endif

    task automatic test_back_to_back();
        stale_mode = 1'b1;
        send_vecs(32'h10203040, 32'h50607080, 16'h1111, 3, 1'b0, 1'b0, 1'b0);
        collect(0, 6);
        send_vecs(32'h0A0B0C0D, 32'h0E0F1011, 16'h2222, 5, 1'b0, 1'b0, 1'b0);
        collect(0, 8);
        stale_mode = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        logic [7:0] junk;
        for (int k = 0; k < 7; k++) begin
            junk = 8'hB0 + 8'(k);
            send_byte(junk, 1'b0);
        end
        bus.in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("reset_mid_op");
        @(posedge clk);
        #1;
        check_reset_values("reset_held");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.core_rst_n !== 1'b1) begin
            failures++; $display("FAIL reset_mid_release: core_rst_n=%b required 1", bus.core_rst_n);
        end
        send_vecs(32'h11223344, 32'h55667788, 16'h0F0F, 1, 1'b0, 1'b0, 1'b0);
        collect(0, 4);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_gapless();
        test_backpressure();
        test_toggle_valid();
        test_done_at_limit();
`ifdef COSINE_FEEDER_TIMEOUT_EN
        test_timeout();
`endif
        test_back_to_back();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cosine_feeder.md
COSINE_FEEDER -- requirements
Module: cosine_feeder

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 64, max WAIT cycles before timeout (only used when COSINE_FEEDER_TIMEOUT_EN is defined).
REQ-002 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  byte-stream valid.
REQ-005 SHALL have port: in_ready  output  1  byte-stream ready.
REQ-006 SHALL have port: in_data  input  8  unsigned vector element.
REQ-007 SHALL have port: A_vec  output  32  packed vector A to the cosine engine.
REQ-008 SHALL have port: B_vec  output  32  packed vector B to the cosine engine.
REQ-009 SHALL have port: core_rst_n  output  1  active-low re-arm reset to the cosine engine.
REQ-010 SHALL have port: start  output  1  start pulse to the cosine engine.
REQ-011 SHALL have port: done  input  1  sticky completion flag from the cosine engine.
REQ-012 SHALL have port: cosine_similarity  input  16  result from the cosine engine.
REQ-013 SHALL have port: res_valid  output  1  result valid.
REQ-014 SHALL have port: res_ready  input  1  result consumer ready.
REQ-015 SHALL have port: res_data  output  16  captured result.
REQ-016 SHALL have port: res_timeout  output  1  result flagged as timed out, qualified by res_valid.

Function
REQ-017 SHALL implement FSM states LOAD_A, LOAD_B, ARM, START, WAIT, RESULT.
REQ-018 SHALL accept a byte on every edge where in_valid and in_ready are both high.
REQ-019 SHALL drive in_ready high only in LOAD_A and LOAD_B.
REQ-020 SHALL pack LSB-first: the k-th accepted byte (k=0..3) of each vector goes to bits [8k+7:8k].
REQ-021 SHALL use a 2-bit byte counter that wraps 3->0 and moves LOAD_A->LOAD_B on the 4th A byte and LOAD_B->ARM on the 4th B byte.
REQ-022 SHALL hold A_vec and B_vec stable from ARM until return to LOAD_A.
REQ-023 SHALL drive core_rst_n low for exactly one cycle in ARM to clear the engine's sticky done, then go to START.
REQ-024 SHALL drive start high for exactly one cycle in START, then go to WAIT.
REQ-025 SHALL ignore done during ARM and START.
REQ-026 SHALL, in WAIT, on the first cycle done is high, register cosine_similarity into res_data and go to RESULT.
REQ-027 SHALL drive res_valid high throughout RESULT and hold res_data and res_timeout stable while res_valid is high and res_ready is low.
REQ-028 SHALL, on res_valid and res_ready both high, go to LOAD_A with byte counter 0; a byte offered in that same cycle is not accepted.
REQ-029 SHALL have no other waits: back-to-back operations add no idle cycles beyond the states above.

Reset
REQ-030 SHALL, when reset is asserted asynchronously, force state LOAD_A, byte counter 0, A_vec=0, B_vec=0, res_data=0, res_valid=0, res_timeout=0, start=0, core_rst_n=0.
REQ-031 SHALL hold core_rst_n low while reset is high and release it on the first edge after reset deasserts.
REQ-032 SHALL, on reset mid-operation in any state, discard partial vectors and any pending result; the first post-reset byte is A byte 0.

Configuration
REQ-033 SHALL, when COSINE_FEEDER_TIMEOUT_EN is defined, count WAIT cycles; if the count reaches TIMEOUT_CYCLES without done, set res_data=16'h0000 and res_timeout=1 and go to RESULT.
REQ-034 SHALL, when COSINE_FEEDER_TIMEOUT_EN is defined, reset the WAIT counter on entry to WAIT, and give done priority if done arrives in the same cycle as the count reaches TIMEOUT_CYCLES.
REQ-035 SHALL, when COSINE_FEEDER_TIMEOUT_EN is undefined, wait in WAIT indefinitely, tie res_timeout to 0, and contain no counter logic.

Verification
REQ-036 SHALL cover: bytes 01,02,03,04,05,06,07,08 streamed without gaps -> A_vec=32'h04030201, B_vec=32'h08070605, one core_rst_n low cycle, then one start cycle.
REQ-037 SHALL cover: done raised with cosine_similarity=16'h0055 while res_ready=0 for 5 cycles -> res_valid held, res_data=16'h0055 stable, and in_ready=0 throughout.
REQ-038 SHALL cover: in_valid toggled every other cycle -> exactly 8 bytes accepted, with correct packing.
REQ-039 SHALL cover: reset asserted after 3 B bytes -> all outputs at reset values, and the next 8 bytes form a fresh A/B pair.
REQ-040 SHALL cover: with the macro defined and TIMEOUT_CYCLES=64, done held 0 -> res_valid with res_timeout=1 and res_data=0 exactly 64 cycles after WAIT entry.
REQ-041 SHALL cover: two back-to-back operations with done already high from the first -> second result captured only after the second start, never the stale value.
